// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch: ID/EX boundary stage of a 5-stage MIPS pipeline.
//   Drives register-file read addresses from rs/rt and resolves both operands
//   with forwarding (MEM over WB over register file). It stalls on load-use
//   hazards and registers the operands plus the decode payload for EX behind
//   a valid/ready handshake.
//
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   in_valid/in_ready              upstream handshake
//   in_rs, in_rt, in_dst           source/destination registers (dst 0 = none)
//   in_is_load, in_ctrl            load flag, opaque decode bundle
//   in_imm, in_pc                  immediate and PC
//   rf_addr1/2, rf_data1/2         register-file read port (combinational)
//   wb_wr, wb_addr, wb_data        register-file write port, snooped
//   mem_fwd_valid/addr/data        MEM-stage forwarding source
//   flush                          squash this stage
//   out_valid/out_ready            downstream handshake
//   out_a, out_b                   resolved operands
//   out_dst, out_is_load, out_ctrl, out_imm, out_pc   registered payload
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int unsigned CTRL_W       = 16,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_dst,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_pc,
  output logic [4:0]        rf_addr1,
  output logic [4:0]        rf_addr2,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              wb_wr,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              mem_fwd_valid,
  input  logic [4:0]        mem_fwd_addr,
  input  logic [31:0]       mem_fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_a,
  output logic [31:0]       out_b,
  output logic [4:0]        out_dst,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_imm,
  output logic [31:0]       out_pc
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] BUBBLES = CNT_W'(LOAD_BUBBLES);

  // Operand select: r0 reads zero, then MEM, then WB, then register file.
  function automatic logic [31:0] sel_operand(
    input logic [4:0]  addr,
    input logic [31:0] rf_val,
    input logic        mem_v,
    input logic [4:0]  mem_a,
    input logic [31:0] mem_d,
    input logic        wb_v,
    input logic [4:0]  wb_a,
    input logic [31:0] wb_d
  );
    logic [31:0] res;
    if (addr == 5'd0)                   res = 32'd0;
    else if (mem_v && (mem_a == addr))  res = mem_d;
    else if (wb_v && (wb_a == addr))    res = wb_d;
    else                                res = rf_val;
    return res;
  endfunction

  logic              out_valid_q,   out_valid_d;
  logic [31:0]       out_a_q,       out_a_d;
  logic [31:0]       out_b_q,       out_b_d;
  logic [4:0]        out_dst_q,     out_dst_d;
  logic              out_is_load_q, out_is_load_d;
  logic [CTRL_W-1:0] out_ctrl_q,    out_ctrl_d;
  logic [31:0]       out_imm_q,     out_imm_d;
  logic [31:0]       out_pc_q,      out_pc_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic [4:0]        ld_dst_q,      ld_dst_d;

  logic hit_out;
  logic hit_cnt;
  logic hz;
  logic capture;
  logic load_leaves;

  assign rf_addr1 = in_rs;
  assign rf_addr2 = in_rt;

  // Load still in the output register, or a load that left within the
  // last LOAD_BUBBLES cycles, targets one of our sources.
  assign hit_out = out_valid_q && out_is_load_q && (out_dst_q != 5'd0) &&
                   ((out_dst_q == in_rs) || (out_dst_q == in_rt));
  assign hit_cnt = (cnt_q != '0) && (ld_dst_q != 5'd0) &&
                   ((ld_dst_q == in_rs) || (ld_dst_q == in_rt));
  assign hz      = in_valid && (hit_out || hit_cnt);

  assign in_ready    = !flush && !hz && (!out_valid_q || out_ready);
  assign capture     = in_valid && in_ready;
  assign load_leaves = out_valid_q && out_ready && out_is_load_q;

  // Next-state for payload, valid and bubble counter.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_dst_d     = out_dst_q;
    out_is_load_d = out_is_load_q;
    out_ctrl_d    = out_ctrl_q;
    out_imm_d     = out_imm_q;
    out_pc_d      = out_pc_q;
    cnt_d         = cnt_q;
    ld_dst_d      = ld_dst_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d   = 1'b1;
      out_a_d       = sel_operand(in_rs, rf_data1, mem_fwd_valid, mem_fwd_addr,
                                  mem_fwd_data, wb_wr, wb_addr, wb_data);
      out_b_d       = sel_operand(in_rt, rf_data2, mem_fwd_valid, mem_fwd_addr,
                                  mem_fwd_data, wb_wr, wb_addr, wb_data);
      out_dst_d     = in_dst;
      out_is_load_d = in_is_load;
      out_ctrl_d    = in_ctrl;
      out_imm_d     = in_imm;
      out_pc_d      = in_pc;
    end else if (out_ready || !out_valid_q) begin
      out_valid_d = 1'b0;
    end

    // Counter runs independently of flush.
    if (load_leaves) begin
      cnt_d    = BUBBLES;
      ld_dst_d = out_dst_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_a_q       <= 32'd0;
      out_b_q       <= 32'd0;
      out_dst_q     <= 5'd0;
      out_is_load_q <= 1'b0;
      out_ctrl_q    <= '0;
      out_imm_q     <= 32'd0;
      out_pc_q      <= 32'd0;
      cnt_q         <= '0;
      ld_dst_q      <= 5'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_dst_q     <= out_dst_d;
      out_is_load_q <= out_is_load_d;
      out_ctrl_q    <= out_ctrl_d;
      out_imm_q     <= out_imm_d;
      out_pc_q      <= out_pc_d;
      cnt_q         <= cnt_d;
      ld_dst_q      <= ld_dst_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_dst     = out_dst_q;
  assign out_is_load = out_is_load_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch: directed stimulus for operand_fetch with a reference
// model (architectural view: hazard window tracked as "cycles since the last
// load left", operands from a register array) checked every negedge, plus
// hand-computed literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned LB     = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_rs = '0, in_rt = '0, in_dst = '0;
  logic              in_is_load = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [31:0]       in_imm = '0, in_pc = '0;
  logic [4:0]        rf_addr1, rf_addr2;
  logic [31:0]       rf_data1, rf_data2;
  logic              wb_wr = 1'b0;
  logic [4:0]        wb_addr = '0;
  logic [31:0]       wb_data = '0;
  logic              mem_fwd_valid = 1'b0;
  logic [4:0]        mem_fwd_addr = '0;
  logic [31:0]       mem_fwd_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_a, out_b;
  logic [4:0]        out_dst;
  logic              out_is_load;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       out_imm, out_pc;

  logic [31:0] rf [32];
  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];

  operand_fetch #(.CTRL_W(CTRL_W), .LOAD_BUBBLES(LB)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst), .in_is_load(in_is_load),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .in_pc(in_pc),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dst(out_dst),
    .out_is_load(out_is_load), .out_ctrl(out_ctrl),
    .out_imm(out_imm), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic              m_valid = 1'b0;
  logic [31:0]       m_a = '0, m_b = '0, m_imm = '0, m_pc = '0;
  logic [4:0]        m_dst = '0;
  logic              m_ld = 1'b0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  bit                have_ld = 1'b0;
  logic [4:0]        last_ld_dst = '0;
  int                cyc = 0;
  int                last_leave = 0;

  function automatic logic [31:0] m_operand(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (mem_fwd_valid && mem_fwd_addr == r) return mem_fwd_data;
    if (wb_wr && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && (r == in_rs || r == in_rt);
  endfunction

  function automatic bit m_ready();
    bit load_ahead, recent_load;
    load_ahead  = m_valid && m_ld && uses(m_dst);
    recent_load = have_ld && ((cyc - last_leave) < int'(LB)) && uses(last_ld_dst);
    return !flush && !(in_valid && (load_ahead || recent_load)) &&
           (!m_valid || out_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_a = '0; m_b = '0; m_dst = '0; m_ld = 1'b0;
      m_ctrl = '0; m_imm = '0; m_pc = '0;
      have_ld = 1'b0; last_ld_dst = '0; cyc = 0; last_leave = 0;
    end else begin
      bit rdy;
      rdy = m_ready();
      if (m_valid && out_ready && m_ld) begin
        have_ld = 1'b1; last_ld_dst = m_dst; last_leave = cyc + 1;
      end
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_a = m_operand(in_rs); m_b = m_operand(in_rt);
        m_dst = in_dst; m_ld = in_is_load; m_ctrl = in_ctrl;
        m_imm = in_imm; m_pc = in_pc;
      end else if (out_ready || !m_valid) m_valid = 1'b0;
      cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rf_addr1", 32'(rf_addr1), 32'(in_rs));
      chk("rf_addr2", 32'(rf_addr2), 32'(in_rt));
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_dst", 32'(out_dst), 32'(m_dst));
        chk("out_is_load", 32'(out_is_load), 32'(m_ld));
        chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
        chk("out_imm", out_imm, m_imm);
        chk("out_pc", out_pc, m_pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic ld, input int tag);
    in_valid   = 1'b1;
    in_rs      = rs;
    in_rt      = rt;
    in_dst     = dst;
    in_is_load = ld;
    in_ctrl    = CTRL_W'(16'hC000 + tag);
    in_imm     = 32'h0000_0100 + 32'(tag);
    in_pc      = 32'h0000_1000 + 32'(tag * 4);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_is_load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
    rf[0] = 32'hDEAD_BEEF;
    rf[3] = 32'h11; rf[4] = 32'h22; rf[7] = 32'h1;
    rf[8] = 32'h88; rf[9] = 32'h99;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_a", out_a, 32'd0);
    chk("reset out_ctrl", 32'(out_ctrl), 32'd0);
    tick();

    // Basic pass-through
    issue(5'd3, 5'd4, 5'd5, 1'b0, 1);
    tick();
    chk("pass out_valid", 32'(out_valid), 32'd1);
    chk("pass out_a", out_a, 32'h11);
    chk("pass out_b", out_b, 32'h22);
    chk("pass out_dst", 32'(out_dst), 32'd5);
    idle(); tick();

    // Forwarding priority
    issue(5'd7, 5'd0, 5'd6, 1'b0, 2);
    wb_wr = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
    mem_fwd_valid = 1'b1; mem_fwd_addr = 5'd7; mem_fwd_data = 32'h3;
    tick();
    chk("fwd mem", out_a, 32'h3);
    chk("fwd r0 rt", out_b, 32'h0);
    mem_fwd_valid = 1'b0; issue(5'd7, 5'd0, 5'd6, 1'b0, 3);
    tick();
    chk("fwd wb", out_a, 32'h2);
    wb_wr = 1'b0; issue(5'd7, 5'd0, 5'd6, 1'b0, 4);
    tick();
    chk("fwd rf", out_a, 32'h1);
    wb_wr = 1'b1; wb_addr = 5'd0; mem_fwd_valid = 1'b1; mem_fwd_addr = 5'd0;
    issue(5'd0, 5'd0, 5'd6, 1'b0, 5);
    tick();
    chk("fwd r0", out_a, 32'h0);
    wb_wr = 1'b0; mem_fwd_valid = 1'b0;
    idle(); tick();

    // Load-use
    issue(5'd1, 5'd2, 5'd8, 1'b1, 6);
    tick();
    issue(5'd8, 5'd0, 5'd10, 1'b0, 7);
    #1 chk("lu stall1 in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu bubble out_valid", 32'(out_valid), 32'd0);
    chk("lu stall2 in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu free in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu consumer valid", 32'(out_valid), 32'd1);
    chk("lu consumer a", out_a, 32'h88);
    chk("lu consumer dst", 32'(out_dst), 32'd10);
    issue(5'd1, 5'd2, 5'd8, 1'b1, 8);
    tick();
    issue(5'd9, 5'd0, 5'd11, 1'b0, 9);
    #1 chk("lu indep in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu indep a", out_a, 32'h99);
    idle(); tick(); tick();

    // Backpressure
    issue(5'd3, 5'd4, 5'd11, 1'b0, 10);
    tick();
    out_ready = 1'b0;
    issue(5'd4, 5'd3, 5'd12, 1'b0, 11);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp hold dst", 32'(out_dst), 32'd11);
      chk("bp hold a", out_a, 32'h11);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp new dst", 32'(out_dst), 32'd12);
    chk("bp new a", out_a, 32'h22);
    idle(); tick();

    // Flush
    issue(5'd3, 5'd4, 5'd13, 1'b0, 12);
    tick();
    flush = 1'b1;
    issue(5'd4, 5'd4, 5'd14, 1'b0, 13);
    #1 chk("flush in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; idle(); tick();
    issue(5'd1, 5'd2, 5'd8, 1'b1, 14);
    tick();
    idle(); flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(5'd8, 5'd0, 5'd15, 1'b0, 15);
    #1 chk("flush keeps cnt", 32'(in_ready), 32'd0);
    tick();
    chk("flush cnt expired", 32'(in_ready), 32'd1);
    tick();
    chk("flush consumer a", out_a, 32'h88);
    idle(); tick(); tick();

    // Reset mid-stall
    issue(5'd1, 5'd2, 5'd8, 1'b1, 16);
    tick();
    issue(5'd9, 5'd9, 5'd16, 1'b0, 17);
    tick();
    issue(5'd8, 5'd3, 5'd17, 1'b0, 18);
    #1 chk("rst pre in_ready", 32'(in_ready), 32'd0);
    chk("rst pre out_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst cnt cleared", 32'(in_ready), 32'd1);
    chk("rst out_dst", 32'(out_dst), 32'd0);
    tick();
    reset = 1'b0;
    #1 chk("rst after in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rst consumer valid", 32'(out_valid), 32'd1);
    chk("rst consumer a", out_a, 32'h88);
    chk("rst consumer b", out_b, 32'h11);
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
